fft_bram_reader: RTL and testbench

- Reads one frame of complex samples from the split real/imag BRAM pair that the FFT capture writer fills.
- Packs 8 consecutive samples per beat into a 384-bit AXI-Stream master output, with tlast on the final beat of the frame.
- Sits between the FFT result BRAMs and the downstream DMA/host stream.
- Start/finish pulses mirror the writer's control style.

---
 rtl/fft_bram_pkg.sv | 22 ++
 rtl/fft_bram_reader_if.sv | 31 +++
 rtl/fft_beat_packer.sv | 101 ++++++++++
 rtl/fft_bram_reader.sv | 122 ++++++++++++
 tb/tb_fft_bram_reader.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_bram_pkg.sv
// Definitions shared by the FFT result BRAM capture writer and reader.
package fft_bram_pkg;

    localparam int SAMPLE_W       = 24;
    localparam int WORD_W         = 32;
    localparam int SLOTS_PER_BEAT = 8;
    localparam int SLOT_W         = 2 * SAMPLE_W;
    localparam int BEAT_W         = SLOTS_PER_BEAT * SLOT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Slot k occupies {im, re} at bit offset k*48 within a beat.
    function automatic int slot_offset(input int k);
        return k * SLOT_W;
    endfunction

endpackage

// File: rtl/fft_bram_reader_if.sv
// BRAM read port plus AXI-Stream master bundle for the FFT result reader.
interface fft_bram_reader_if;
    import fft_bram_pkg::*;

    logic [31:0]       bram_addr;
    logic              bram_en;
    logic [3:0]        bram_we;
    logic              bram_rst;
    logic [WORD_W-1:0] bram_dout_re;
    logic [WORD_W-1:0] bram_dout_im;

    logic [BEAT_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    modport master (
        output bram_addr, bram_en, bram_we, bram_rst,
        input  bram_dout_re, bram_dout_im,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  bram_addr, bram_en, bram_we, bram_rst,
        output bram_dout_re, bram_dout_im,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/fft_beat_packer.sv
// Packs returned real/imag words into 8-slot beats behind an AXI-Stream output register.
// FFT_BRAM_READER_SAT_EN selects signed 24-bit saturation instead of truncation.
module fft_beat_packer
    import fft_bram_pkg::*;
#(
    parameter int FRAME_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_re,
    input  logic [WORD_W-1:0] in_im,
    input  logic              tready,
    output logic [BEAT_W-1:0] tdata,
    output logic              tvalid,
    output logic              tlast,
    output logic [3:0]        slot_count,
    output logic              move,
    output logic              frame_done
);

    localparam int BEATS      = FRAME_WORDS / SLOTS_PER_BEAT;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    logic [BEAT_W-1:0]     asm_q;
    logic [3:0]            slot_q;
    logic [3:0]            slot_base;
    logic [2:0]            wr_slot;
    logic [BEAT_CNT_W-1:0] beat_q;
    logic [SAMPLE_W-1:0]   re_s;
    logic [SAMPLE_W-1:0]   im_s;

`ifdef FFT_BRAM_READER_SAT_EN
    function automatic logic [SAMPLE_W-1:0] sat24(input logic [WORD_W-1:0] w);
        if (!w[31] && (w[30:23] != 8'h00))
            return 24'h7FFFFF;
        else if (w[31] && (w[30:23] != 8'hFF))
            return 24'h800000;
        else
            return w[SAMPLE_W-1:0];
    endfunction

    assign re_s = sat24(in_re);
    assign im_s = sat24(in_im);
`else
    logic unused_hi_bits;

    assign re_s = in_re[SAMPLE_W-1:0];
    assign im_s = in_im[SAMPLE_W-1:0];
    assign unused_hi_bits = ^{in_re[WORD_W-1:SAMPLE_W], in_im[WORD_W-1:SAMPLE_W]};
`endif

    // A full assembly register hands off whenever the output register is free this cycle;
    // a word arriving in that same cycle starts the next beat at slot 0.
    assign move       = (slot_q == 4'(SLOTS_PER_BEAT)) && (!tvalid || tready);
    assign slot_base  = move ? 4'd0 : slot_q;
    assign wr_slot    = slot_base[2:0];
    assign slot_count = slot_q;
    assign frame_done = tvalid && tready && tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q  <= '0;
            slot_q <= '0;
        end else if (clear) begin
            slot_q <= '0;
        end else begin
            for (int k = 0; k < SLOTS_PER_BEAT; k++) begin
                if (in_valid && (wr_slot == 3'(k))) begin
                    asm_q[slot_offset(k) +: SAMPLE_W]            <= re_s;
                    asm_q[slot_offset(k) + SAMPLE_W +: SAMPLE_W] <= im_s;
                end
            end
            slot_q <= slot_base + {3'd0, in_valid};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdata  <= '0;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            beat_q <= '0;
        end else if (clear) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            beat_q <= '0;
        end else if (move) begin
            tdata  <= asm_q;
            tvalid <= 1'b1;
            tlast  <= (beat_q == LAST_BEAT);
            beat_q <= beat_q + BEAT_CNT_W'(1);
        end else if (tready) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
        end
    end

endmodule

// File: rtl/fft_bram_reader.sv
// Reads one frame from the FFT real/imag BRAM pair and streams it as 384-bit beats.
// Optional macro FFT_BRAM_READER_SAT_EN enables 24-bit saturation in the packer.
module fft_bram_reader
    import fft_bram_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int FRAME_WORDS = 2048,
    parameter int RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              finish,
    fft_bram_reader_if.master bus
);

    localparam int WCNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(FRAME_WORDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [WCNT_W-1:0] word_q;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic              accept;
    logic              arrive;
    logic              issue;
    logic              move;
    logic              frame_done;
    logic [3:0]        pending;
    logic [3:0]        slot_count;

    assign accept = (state_q == ST_IDLE) && start;
    assign arrive = rd_pipe_q[RD_LAT-1];

    always_comb begin
        pending = '0;
        for (int i = 0; i < RD_LAT - 1; i++)
            pending = pending + {3'd0, rd_pipe_q[i]};
    end

    // Captured plus in-flight words may never exceed one beat, counting a hand-off this cycle as free space.
    assign issue = (state_q == ST_READ) &&
                   (((move ? 4'd0 : slot_count) + {3'd0, arrive} + pending) < 4'(SLOTS_PER_BEAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_READ;
            end
            ST_READ: begin
                busy = 1'b1;
                if (issue && (word_q == LAST_WORD))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (frame_done)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            word_q    <= '0;
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q <= RD_LAT'({rd_pipe_q, issue});
            if (accept) begin
                addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
                word_q <= '0;
            end else if (issue) begin
                addr_q <= addr_q + ADDR_W'(4);
                word_q <= word_q + WCNT_W'(1);
            end
        end
    end

    assign bus.bram_addr = 32'(addr_q);
    assign bus.bram_en   = issue;
    assign bus.bram_we   = 4'b0000;
    assign bus.bram_rst  = 1'b0;

    fft_beat_packer #(
        .FRAME_WORDS (FRAME_WORDS)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .in_valid   (arrive),
        .in_re      (bus.bram_dout_re),
        .in_im      (bus.bram_dout_im),
        .tready     (bus.m_axis_tready),
        .tdata      (bus.m_axis_tdata),
        .tvalid     (bus.m_axis_tvalid),
        .tlast      (bus.m_axis_tlast),
        .slot_count (slot_count),
        .move       (move),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_fft_bram_reader.sv
// Randomized self-checking bench for fft_bram_reader against a frame-level reference model.
module tb_fft_bram_reader;
    import fft_bram_pkg::*;

    localparam int ADDR_W      = 13;
    localparam int FRAME_WORDS = 16;
    localparam int RD_LAT      = 1;
    localparam int BEATS       = FRAME_WORDS / SLOTS_PER_BEAT;
    localparam int MEM_WORDS   = 1 << (ADDR_W - 2);

    typedef logic [BEAT_W-1:0] beat_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              finish;

    fft_bram_reader_if bus();

    fft_bram_reader #(
        .ADDR_W      (ADDR_W),
        .FRAME_WORDS (FRAME_WORDS),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .finish    (finish),
        .bus       (bus)
    );

    logic [31:0] mem_re [0:MEM_WORDS-1];
    logic [31:0] mem_im [0:MEM_WORDS-1];

    int          checks = 0;
    int          failures = 0;
    int          ready_pct = 100;
    int          finish_count = 0;
    bit          in_frame = 0;
    logic [31:0] exp_addr [$];
    beat_t       exp_beats [$];
    bit          exp_last [$];
    logic [31:0] addr_log [$];
    beat_t       got_beats [$];
    bit          got_last [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.bram_en) begin
            bus.bram_dout_re <= mem_re[bus.bram_addr[ADDR_W-1:2]];
            bus.bram_dout_im <= mem_im[bus.bram_addr[ADDR_W-1:2]];
        end
    end

    initial begin
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.m_axis_tready = (int'($urandom_range(0, 99)) < ready_pct);
        end
    end

    task automatic checkOutput(input string name, input beat_t act, input beat_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] toSample(input logic [31:0] w);
`ifdef FFT_BRAM_READER_SAT_EN
        if ($signed(w) > 32'sd8388607)
            return 24'h7FFFFF;
        if ($signed(w) < -32'sd8388608)
            return 24'h800000;
`endif
        return 24'(w);
    endfunction

    // Frame expectation: words are read at consecutive wrapped addresses and dealt 8 per beat.
    task automatic buildFrame(input logic [ADDR_W-1:0] base);
        beat_t beat;
        int    n;
        int    a;
        exp_addr.delete();
        exp_beats.delete();
        exp_last.delete();
        for (int b = 0; b < BEATS; b++) begin
            beat = '0;
            for (int k = 0; k < SLOTS_PER_BEAT; k++) begin
                n = b * SLOTS_PER_BEAT + k;
                a = ((int'(base) & ~3) + 4 * n) % (1 << ADDR_W);
                beat[k*48 +: 24]      = toSample(mem_re[a/4]);
                beat[k*48 + 24 +: 24] = toSample(mem_im[a/4]);
                exp_addr.push_back(32'(a));
            end
            exp_beats.push_back(beat);
            exp_last.push_back(b == BEATS - 1);
        end
    endtask

    task automatic fillRandom();
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_re[i] = $urandom;
            mem_im[i] = $urandom;
        end
    endtask

    task automatic pulseStart(input logic [ADDR_W-1:0] base);
        addr_log.delete();
        got_beats.delete();
        got_last.delete();
        finish_count = 0;
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_frame = 1'b1;
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int pct, input bit restart);
        buildFrame(base);
        ready_pct = pct;
        pulseStart(base);
        if (restart) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            base_addr = ~base;
            @(negedge clk);
            start = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            if (!in_frame) break;
            @(negedge clk);
            #1;
        end
        checkOutput("frame_timeout", beat_t'(in_frame), beat_t'(0));
        in_frame = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("finish_count", beat_t'(finish_count), beat_t'(1));
        checkOutput("beats_missing", beat_t'(exp_beats.size()), beat_t'(0));
        checkOutput("reads_missing", beat_t'(exp_addr.size()), beat_t'(0));
    endtask

    // Single compare process: addresses, beats, stall stability and busy/finish framing.
    bit    prev_stall = 0;
    beat_t prev_data;
    bit    prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (bus.bram_en) begin
                addr_log.push_back(bus.bram_addr);
                checkOutput("bram_we", beat_t'(bus.bram_we), beat_t'(0));
                if (exp_addr.size() == 0)
                    checkOutput("unexpected_read", beat_t'(bus.bram_en), beat_t'(0));
                else
                    checkOutput("bram_addr", beat_t'(bus.bram_addr), beat_t'(exp_addr.pop_front()));
            end
            if (prev_stall) begin
                checkOutput("stall_tvalid", beat_t'(bus.m_axis_tvalid), beat_t'(1));
                checkOutput("stall_tdata", bus.m_axis_tdata, prev_data);
                checkOutput("stall_tlast", beat_t'(bus.m_axis_tlast), beat_t'(prev_last));
            end
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_data  = bus.m_axis_tdata;
            prev_last  = bus.m_axis_tlast;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                got_beats.push_back(bus.m_axis_tdata);
                got_last.push_back(bus.m_axis_tlast);
                if (exp_beats.size() == 0) begin
                    checkOutput("unexpected_beat", beat_t'(bus.m_axis_tvalid), beat_t'(0));
                end else begin
                    checkOutput("beat_tdata", bus.m_axis_tdata, exp_beats.pop_front());
                    checkOutput("beat_tlast", beat_t'(bus.m_axis_tlast), beat_t'(exp_last.pop_front()));
                end
            end
            if (finish) begin
                finish_count++;
                checkOutput("busy_at_finish", beat_t'(busy), beat_t'(0));
                if (!in_frame)
                    checkOutput("spurious_finish", beat_t'(finish), beat_t'(0));
                checkOutput("beats_left_at_finish", beat_t'(exp_beats.size()), beat_t'(0));
                in_frame = 1'b0;
            end else if (in_frame) begin
                checkOutput("busy_in_frame", beat_t'(busy), beat_t'(1));
            end else begin
                checkOutput("busy_idle", beat_t'(busy), beat_t'(0));
            end
        end
    end

    beat_t       b0;
    logic [31:0] last_a;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        bus.bram_dout_re = '0;
        bus.bram_dout_im = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tvalid", beat_t'(bus.m_axis_tvalid), beat_t'(0));
        checkOutput("rst_tlast", beat_t'(bus.m_axis_tlast), beat_t'(0));
        checkOutput("rst_tdata", bus.m_axis_tdata, beat_t'(0));
        checkOutput("rst_busy", beat_t'(busy), beat_t'(0));
        checkOutput("rst_finish", beat_t'(finish), beat_t'(0));
        checkOutput("rst_bram_en", beat_t'(bus.bram_en), beat_t'(0));
        checkOutput("rst_bram_addr", beat_t'(bus.bram_addr), beat_t'(0));
        checkOutput("rst_bram_we", beat_t'(bus.bram_we), beat_t'(0));
        checkOutput("rst_bram_rst", beat_t'(bus.bram_rst), beat_t'(0));
        rst = 1'b0;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_re[i] = 32'(i);
            mem_im[i] = 32'(32'h100 + i);
        end
        $display("[TB] ramp frame, tready high");
        applyStimulus('0, 100, 1'b0);
        b0 = (got_beats.size() > 0) ? got_beats[0] : '1;
        checkOutput("pin_b0_s0_re", beat_t'(b0[23:0]), beat_t'(24'h000000));
        checkOutput("pin_b0_s0_im", beat_t'(b0[47:24]), beat_t'(24'h000100));
        checkOutput("pin_b0_s7_re", beat_t'(b0[7*48 +: 24]), beat_t'(24'h000007));
        checkOutput("pin_beat_count", beat_t'(got_beats.size()), beat_t'(2));
        checkOutput("pin_b0_tlast", beat_t'((got_last.size() > 0) ? got_last[0] : 1'b1), beat_t'(0));
        checkOutput("pin_b1_tlast", beat_t'((got_last.size() > 1) ? got_last[1] : 1'b0), beat_t'(1));
        last_a = (addr_log.size() > 0) ? addr_log[addr_log.size()-1] : 32'hFFFF_FFFF;
        checkOutput("pin_last_addr", beat_t'(last_a), beat_t'(32'h3C));

        $display("[TB] ramp frame, tready 30 percent");
        applyStimulus('0, 30, 1'b0);

        $display("[TB] wrapping base address");
        applyStimulus(13'h1FF0, 100, 1'b0);
        checkOutput("pin_wrap_first", beat_t'((addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF), beat_t'(32'h1FF0));
        checkOutput("pin_wrap_zero", beat_t'((addr_log.size() > 4) ? addr_log[4] : 32'hFFFF_FFFF), beat_t'(32'h0000));
        checkOutput("pin_wrap_last", beat_t'((addr_log.size() > 15) ? addr_log[15] : 32'hFFFF_FFFF), beat_t'(32'h002C));

        $display("[TB] restart pulse mid-frame");
        fillRandom();
        applyStimulus(ADDR_W'($urandom_range(0, 8191)), 30, 1'b1);

        $display("[TB] width conversion");
        fillRandom();
        mem_re[0] = 32'h00FF_FFFF;
        mem_im[0] = 32'hFF00_0000;
        applyStimulus('0, 100, 1'b0);
        b0 = (got_beats.size() > 0) ? got_beats[0] : '1;
`ifdef FFT_BRAM_READER_SAT_EN
        checkOutput("pin_sat_pos", beat_t'(b0[23:0]), beat_t'(24'h7FFFFF));
        checkOutput("pin_sat_neg", beat_t'(b0[47:24]), beat_t'(24'h800000));
`else
        checkOutput("pin_trunc_pos", beat_t'(b0[23:0]), beat_t'(24'hFFFFFF));
        checkOutput("pin_trunc_neg", beat_t'(b0[47:24]), beat_t'(24'h000000));
`endif

        $display("[TB] reset mid-frame");
        fillRandom();
        buildFrame('0);
        ready_pct = 100;
        pulseStart('0);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (got_beats.size() >= 1) break;
        end
        checkOutput("abort_first_beat", beat_t'(got_beats.size()), beat_t'(1));
        ready_pct = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            #1;
            if (bus.m_axis_tvalid) break;
        end
        checkOutput("abort_tvalid_pre", beat_t'(bus.m_axis_tvalid), beat_t'(1));
        checkOutput("abort_busy_pre", beat_t'(busy), beat_t'(1));
        rst = 1'b1;
        #1;
        checkOutput("abort_tvalid", beat_t'(bus.m_axis_tvalid), beat_t'(0));
        checkOutput("abort_busy", beat_t'(busy), beat_t'(0));
        checkOutput("abort_bram_en", beat_t'(bus.bram_en), beat_t'(0));
        checkOutput("abort_finish", beat_t'(finish), beat_t'(0));
        in_frame = 1'b0;
        exp_addr.delete();
        exp_beats.delete();
        exp_last.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_no_finish", beat_t'(finish_count), beat_t'(0));
        applyStimulus(ADDR_W'($urandom_range(0, 8191)), 50, 1'b0);

        $display("[TB] random frames");
        for (int i = 0; i < 4; i++) begin
            fillRandom();
            applyStimulus(ADDR_W'($urandom_range(0, 8191)), int'($urandom_range(20, 100)), i == 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
